// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 SCCB configuration write master:
// FSM encoding, default device write byte and quarter-phase indices.
package ov5640_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BYTE,
    ACK,
    STOP,
    END
  } sccb_state_t;

  localparam logic [7:0] DEV_ADDR_W = 8'h78;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/ov5640_sccb_wr_tick_gen.sv
// Free-running divider: one-cycle qtick every QDIV sys_clk cycles and an
// i2c_clk of period QDIV whose falling edge lines up with qtick.
module sccb_tick_gen #(
  parameter int QDIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic qtick,
  output logic i2c_clk
);

  localparam int CW = $clog2(QDIV);
  localparam logic [CW-1:0] LAST = CW'(QDIV - 1);
  localparam logic [CW-1:0] HALF = CW'(QDIV / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      i2c_clk <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (cnt == LAST || cnt == HALF)
        i2c_clk <= ~i2c_clk;
    end
  end

  assign qtick = (cnt == LAST);

endmodule

// File: rtl/ov5640_sccb_wr.sv
// SCCB 3-phase write master: sends {dev, addr_hi, addr_lo, val} per request,
// pulses cfg_end for one i2c_clk period and keeps a sticky NACK flag.
module ov5640_sccb_wr
  import ov5640_pkg::*;
#(
  parameter int          SYS_CLK_FREQ = 50_000_000,
  parameter int          SCL_FREQ     = 250_000,
  parameter logic [6:0]  DEV_ADDR     = DEV_ADDR_W[7:1],
  parameter int          QDIV         = SYS_CLK_FREQ / (SCL_FREQ * 4)
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  output logic        i2c_clk,
  output logic        cfg_end,
  output logic        busy,
  output logic        ack_err,
  output logic        scl,
  inout  logic        sda
);

  localparam logic [7:0] WR_BYTE = {DEV_ADDR, 1'b0};

  sccb_state_t state, state_n;
  logic [1:0]  q, q_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [1:0]  byte_cnt, byte_cnt_n;
  logic [31:0] shreg, shreg_n;
  logic        busy_n;
  logic        start_d;
  logic        start_rise;
  logic        qtick;
  logic        scl_n;
  logic        sda_low, sda_low_n;

  sccb_tick_gen #(.QDIV(QDIV)) u_tick (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .qtick   (qtick),
    .i2c_clk (i2c_clk)
  );

  assign start_rise = cfg_start & ~start_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      q        <= Q0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      start_d  <= 1'b0;
      cfg_end  <= 1'b0;
      ack_err  <= 1'b0;
      scl      <= 1'b1;
      sda_low  <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      shreg    <= shreg_n;
      busy     <= busy_n;
      start_d  <= cfg_start;
      cfg_end  <= (state_n == END);
      scl      <= scl_n;
      sda_low  <= sda_low_n;
      if (qtick && state == ACK && q == Q2 && sda)
        ack_err <= 1'b1;
    end
  end

  // Sequencing advances only on qtick; bus levels are decoded from the
  // next state so the pins change on the same edge as the quarter.
  always_comb begin
    state_n    = state;
    q_n        = q;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    shreg_n    = shreg;
    busy_n     = busy;

    if (state == IDLE && !busy && start_rise) begin
      shreg_n = {WR_BYTE, cfg_data};
      busy_n  = 1'b1;
    end

    if (qtick) begin
      q_n = q + 2'd1;
      case (state)
        IDLE: begin
          q_n = Q0;
          if (busy)
            state_n = START;
        end
        START: begin
          if (q == Q3) begin
            state_n    = BYTE;
            bit_cnt_n  = 3'd7;
            byte_cnt_n = 2'd0;
          end
        end
        BYTE: begin
          if (q == Q3) begin
            shreg_n   = {shreg[30:0], 1'b0};
            bit_cnt_n = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0)
              state_n = ACK;
          end
        end
        ACK: begin
          if (q == Q3) begin
            if (byte_cnt == 2'd3) begin
              state_n = STOP;
            end else begin
              state_n    = BYTE;
              byte_cnt_n = byte_cnt + 2'd1;
              bit_cnt_n  = 3'd7;
            end
          end
        end
        STOP: begin
          if (q == Q3)
            state_n = END;
        end
        END: begin
          state_n = IDLE;
          q_n     = Q0;
          busy_n  = 1'b0;
        end
        default: begin
          state_n = IDLE;
          q_n     = Q0;
        end
      endcase
    end

    scl_n     = 1'b1;
    sda_low_n = 1'b0;
    case (state_n)
      START: begin
        scl_n     = (q_n != Q3);
        sda_low_n = (q_n != Q0);
      end
      BYTE: begin
        scl_n     = (q_n == Q1) || (q_n == Q2);
        sda_low_n = ~shreg_n[31];
      end
      ACK: begin
        scl_n     = (q_n == Q1) || (q_n == Q2);
        sda_low_n = 1'b0;
      end
      STOP: begin
        scl_n     = (q_n != Q0);
        sda_low_n = (q_n != Q3);
      end
      default: begin
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
      end
    endcase
  end

  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule
